// File: rtl/systolic_seq_pkg.sv
// systolic_seq_pkg
//   Shared types and constants for the systolic array sequencer.
//   - LANES / DW       : array edge width (8 lanes of 32-bit data)
//   - KMAX_DEF         : default maximum beats per tile job
//   - TIMEOUT_DEF      : default drain timeout in cycles
//   - addrgen_t        : address-generation mode forwarded to the array
//   - seq_state_t      : sequencer FSM states
//   - pack_edge()      : builds one {en, cm, data} skew-line word
package systolic_seq_pkg;

  localparam int LANES       = 8;
  localparam int DW          = 32;
  localparam int KMAX_DEF    = 256;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ADDR_LINEAR    = 2'd0,
    ADDR_TRANSPOSE = 2'd1,
    ADDR_BLOCK     = 2'd2,
    ADDR_STRIDED   = 2'd3
  } addrgen_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_FEED    = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } seq_state_t;

  typedef logic [LANES-1:0][DW-1:0]             lane_vec_t;
  typedef logic [LANES-1:0][LANES-1:0][DW-1:0]  pe_data_t;
  typedef logic [LANES-1:0][LANES-1:0]          pe_flag_t;

  // A bubble slot carries no marker and zero data so the array never sees
  // stale operands on a disabled edge.
  function automatic logic [DW+1:0] pack_edge(input logic en, input logic cm,
                                               input logic [DW-1:0] d);
    return {en, cm & en, (en ? d : {DW{1'b0}})};
  endfunction

endpackage

// File: rtl/systolic_seq_if.sv
// systolic_seq_if
//   Operand stream from the operand buffers into the sequencer.
//   - op_valid : a beat (one A column + one B row) is presented
//   - op_ready : sequencer accepts the beat this cycle
//   - a_col    : A column, lane i feeds array row i
//   - b_row    : B row, lane j feeds array column j
//   master = operand buffer side, slave = sequencer side.
interface systolic_seq_if;
  import systolic_seq_pkg::*;

  logic      op_valid;
  logic      op_ready;
  lane_vec_t a_col;
  lane_vec_t b_row;

  modport master (output op_valid, output a_col, output b_row, input op_ready);
  modport slave  (input op_valid, input a_col, input b_row, output op_ready);

endinterface

// File: rtl/systolic_seq_skew_line.sv
// skew_line
//   Fixed-depth register chain used to skew one edge lane of the array.
//   - clk, rst : clock, asynchronous active-low reset
//   - din      : word entering the chain
//   - dout     : word after DEPTH clock edges
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] stages;

  // Plain shift chain; reset flushes every stage so no old beat leaks out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stages <= '0;
    end else begin
      stages[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        stages[k] <= stages[k-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/systolic_seq.sv
// systolic_seq
//   Sequencer between the operand buffers and the 8x8 systolic PE array.
//   Accepts one tile job of k_len beats, skews them into the array edges,
//   optionally preloads accumulators, then waits for every PE's out_ready.
//   Ports:
//   - clk, rst             : clock, asynchronous active-low reset
//   - start, k_len         : job request (IDLE only) and beat count (0 -> 1)
//   - preload, c_in        : accumulator preload request and values
//   - addr_type_in/mixed_in: job modes forwarded to addr_type/mixed
//   - op                   : operand stream (slave side)
//   - enleft/cmleft/aleft  : left edge enable / last-beat / data (rows)
//   - enup/cmup/bup        : top edge enable / last-beat / data (columns)
//   - we, c, wben          : accumulator preload path
//   - out_ready            : per-PE result ready flags
//   - busy, done, err      : job active, completion pulse, sticky timeout
module systolic_seq
  import systolic_seq_pkg::*;
#(
  parameter int KMAX    = KMAX_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int KW      = $clog2(KMAX+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          preload,
  input  addrgen_t      addr_type_in,
  input  logic          mixed_in,
  input  pe_data_t      c_in,
  systolic_seq_if.slave op,
  output logic [LANES-1:0] enleft,
  output logic [LANES-1:0] enup,
  output logic [LANES-1:0] cmleft,
  output logic [LANES-1:0] cmup,
  output lane_vec_t     aleft,
  output lane_vec_t     bup,
  output pe_flag_t      we,
  output pe_data_t      c,
  output logic          wben,
  output addrgen_t      addr_type,
  output logic          mixed,
  input  pe_flag_t      out_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int TW = $clog2(TIMEOUT+1);

  seq_state_t    state, next_state;
  logic [KW-1:0] k_last;
  logic [KW-1:0] beat_cnt;
  logic [TW-1:0] drain_cnt;
  pe_flag_t      mask;

  logic feed, accept, last_beat, cm_in, mask_full, timeout_hit;

  assign feed        = (state == S_FEED);
  assign accept      = feed && op.op_valid;
  assign last_beat   = (beat_cnt == k_last);
  assign cm_in       = accept && last_beat;
  assign mask_full   = &mask;
  assign timeout_hit = (state == S_DRAIN) && !mask_full &&
                       (drain_cnt == TW'(TIMEOUT-1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Job bookkeeping: latched job fields, beat count, drain timer, ready mask
  // and the sticky timeout flag. k_last stores k_len-1 so a zero-length
  // request behaves as a single beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_last    <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      mask      <= '0;
      addr_type <= ADDR_LINEAR;
      mixed     <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        k_last    <= (k_len == '0) ? '0 : k_len - KW'(1);
        beat_cnt  <= '0;
        mask      <= '0;
        addr_type <= addr_type_in;
        mixed     <= mixed_in;
        err       <= 1'b0;
      end
      if (accept) begin
        beat_cnt <= beat_cnt + KW'(1);
      end
      // Ready pulses can arrive early, so the mask collects during FEED too.
      if (state == S_FEED || state == S_DRAIN) begin
        mask <= mask | out_ready;
      end
      if (state == S_DONE) begin
        mask <= '0;
      end
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + TW'(1) : '0;
      if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end

  // Next-state and decoded outputs.
  always_comb begin
    next_state  = state;
    op.op_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    wben        = 1'b0;
    we          = '0;
    c           = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          next_state = preload ? S_PRELOAD : S_FEED;
        end
      end
      S_PRELOAD: begin
        busy       = 1'b1;
        wben       = 1'b1;
        we         = '1;
        c          = c_in;
        next_state = S_FEED;
      end
      S_FEED: begin
        busy        = 1'b1;
        op.op_ready = 1'b1;
        if (accept && last_beat) begin
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (mask_full || timeout_hit) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Lane i gets i+1 stages so the wavefront reaches row/column 7 seven
  // cycles after row/column 0.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW+1:0] row_q, col_q;

    skew_line #(.DEPTH(i+1), .W(DW+2)) u_row (
      .clk  (clk),
      .rst  (rst),
      .din  (pack_edge(accept, cm_in, op.a_col[i])),
      .dout (row_q)
    );

    skew_line #(.DEPTH(i+1), .W(DW+2)) u_col (
      .clk  (clk),
      .rst  (rst),
      .din  (pack_edge(accept, cm_in, op.b_row[i])),
      .dout (col_q)
    );

    assign enleft[i] = row_q[DW+1];
    assign cmleft[i] = row_q[DW];
    assign aleft[i]  = row_q[DW-1:0];
    assign enup[i]   = col_q[DW+1];
    assign cmup[i]   = col_q[DW];
    assign bup[i]    = col_q[DW-1:0];
  end

endmodule

// File: tb/tb_systolic_seq.sv
// tb_systolic_seq
//   Directed bench for systolic_seq: skew timing, bubbles, preload,
//   drain timeout, per-PE ready collection and asynchronous reset abort.
module tb_systolic_seq;
  import systolic_seq_pkg::*;

  localparam int KW  = 9;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          preload = 1'b0;
  addrgen_t      addr_type_in = ADDR_LINEAR;
  logic          mixed_in = 1'b0;
  pe_data_t      c_in = '0;
  pe_flag_t      out_ready = '0;

  logic [LANES-1:0] enleft, enup, cmleft, cmup;
  lane_vec_t     aleft, bup;
  pe_flag_t      we;
  pe_data_t      c;
  logic          wben, mixed, busy, done, err;
  addrgen_t      addr_type;

  int vec_count   = 0;
  int miscompares = 0;
  int n;

  systolic_seq_if op_if ();

  systolic_seq #(.KMAX(256), .TIMEOUT(TMO), .KW(KW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .k_len        (k_len),
    .preload      (preload),
    .addr_type_in (addr_type_in),
    .mixed_in     (mixed_in),
    .c_in         (c_in),
    .op           (op_if),
    .enleft       (enleft),
    .enup         (enup),
    .cmleft       (cmleft),
    .cmup         (cmup),
    .aleft        (aleft),
    .bup          (bup),
    .we           (we),
    .c            (c),
    .wben         (wben),
    .addr_type    (addr_type),
    .mixed        (mixed),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents a job request for one edge; returns at the negedge after it.
  task automatic applyStimulus(input int k, input logic pre, input addrgen_t at,
                               input logic mx);
    start        = 1'b1;
    k_len        = KW'(k);
    preload      = pre;
    addr_type_in = at;
    mixed_in     = mx;
    step();
    start        = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cycles);
    cycles = 0;
    while (!done && cycles < max) begin
      step();
      cycles++;
    end
  endtask

  // One-cycle pulse of every out_ready flag, then wait for completion.
  task automatic finish_job(input string tag);
    int cyc;
    out_ready = '1;
    step();
    out_ready = '0;
    wait_done(20, cyc);
    checkOutput(tag, 64'(done), 64'd1);
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cm_row_cnt [LANES];
    int cm_col_cnt [LANES];
    logic [7:0] cm_ok;
    logic [4:0] en_seq, cm_seq, enu_seq;
    int bad, seen;

    op_if.op_valid = 1'b0;
    op_if.a_col    = '0;
    op_if.b_row    = '0;

    // ---------------- reset state ----------------
    step();
    step();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_op_ready", 64'(op_if.op_ready), 64'd0);
    checkOutput("rst_edges", 64'({enleft, enup, cmleft, cmup}), 64'd0);
    checkOutput("rst_data", 64'({|aleft, |bup, |c}), 64'd0);
    checkOutput("rst_we", 64'(we), 64'd0);
    checkOutput("rst_flags", 64'({wben, done, err}), 64'd0);
    rst = 1'b1;
    step();

    // ---------------- test 1: single beat ----------------
    for (int i = 0; i < LANES; i++) begin
      op_if.a_col[i] = 32'hA000_0000 + 32'(i);
      op_if.b_row[i] = 32'hB000_0000 + 32'(i);
      cm_row_cnt[i]  = 0;
      cm_col_cnt[i]  = 0;
    end
    op_if.op_valid = 1'b1;
    applyStimulus(1, 1'b0, ADDR_BLOCK, 1'b1);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    checkOutput("t1_op_ready", 64'(op_if.op_ready), 64'd1);
    checkOutput("t1_addr_type", 64'(addr_type), 64'(ADDR_BLOCK));
    checkOutput("t1_mixed", 64'(mixed), 64'd1);
    step();
    op_if.op_valid = 1'b0;
    checkOutput("t1_aleft0", 64'(aleft[0]), 64'hA000_0000);
    checkOutput("t1_bup0", 64'(bup[0]), 64'hB000_0000);
    checkOutput("t1_enleft_t1", 64'(enleft), 64'h01);
    checkOutput("t1_op_ready_drop", 64'(op_if.op_ready), 64'd0);
    for (int cyc = 2; cyc <= 12; cyc++) begin
      for (int i = 0; i < LANES; i++) begin
        if (cmleft[i]) cm_row_cnt[i]++;
        if (cmup[i])   cm_col_cnt[i]++;
      end
      if (cyc == 9) begin
        checkOutput("t1_aleft7", 64'(aleft[7]), 64'hA000_0007);
        checkOutput("t1_bup7", 64'(bup[7]), 64'hB000_0007);
        checkOutput("t1_enleft_t8", 64'(enleft), 64'h80);
        checkOutput("t1_cmup_t8", 64'(cmup), 64'h80);
      end
      if (cyc == 12) out_ready = '1;
      step();
    end
    out_ready = '0;
    checkOutput("t1_done_early", 64'(done), 64'd0);
    checkOutput("t1_busy_drain", 64'(busy), 64'd1);
    step();
    checkOutput("t1_done", 64'(done), 64'd1);
    checkOutput("t1_busy_done", 64'(busy), 64'd0);
    step();
    checkOutput("t1_done_once", 64'(done), 64'd0);
    checkOutput("t1_addr_hold", 64'(addr_type), 64'(ADDR_BLOCK));
    for (int i = 0; i < LANES; i++) begin
      cm_ok[i] = (cm_row_cnt[i] == 1) && (cm_col_cnt[i] == 1);
    end
    checkOutput("t1_cm_once", 64'(cm_ok), 64'hFF);

    // ---------------- test 2: k_len=4 with a bubble ----------------
    en_seq  = '0;
    cm_seq  = '0;
    enu_seq = '0;
    applyStimulus(4, 1'b0, ADDR_LINEAR, 1'b0);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc >= 5 && cyc <= 9) begin
        en_seq  = {en_seq[3:0], enleft[3]};
        cm_seq  = {cm_seq[3:0], cmleft[3]};
        enu_seq = {enu_seq[3:0], enup[3]};
      end
      if (cyc == 5) checkOutput("t2_op_ready_last", 64'(op_if.op_ready), 64'd1);
      if (cyc == 6) begin
        checkOutput("t2_bubble_data", 64'(aleft[3]), 64'd0);
        checkOutput("t2_op_ready_drop", 64'(op_if.op_ready), 64'd0);
      end
      if (cyc == 9) checkOutput("t2_last_data", 64'(aleft[3]), 64'h3300_0003);
      case (cyc)
        1: begin
          op_if.op_valid = 1'b1;
          op_if.a_col[3] = 32'h3300_0000;
          op_if.b_row[3] = 32'h4400_0000;
        end
        2: op_if.op_valid = 1'b0;
        3, 4, 5: begin
          op_if.op_valid = 1'b1;
          op_if.a_col[3] = 32'h3300_0000 + 32'(cyc - 2);
          op_if.b_row[3] = 32'h4400_0000 + 32'(cyc - 2);
        end
        default: op_if.op_valid = 1'b0;
      endcase
      step();
    end
    checkOutput("t2_enleft3_seq", 64'(en_seq), 64'b10111);
    checkOutput("t2_enup3_seq", 64'(enu_seq), 64'b10111);
    checkOutput("t2_cmleft3_seq", 64'(cm_seq), 64'b00001);
    finish_job("t2_done");

    // ---------------- test 3: preload ----------------
    for (int i = 0; i < LANES; i++)
      for (int j = 0; j < LANES; j++)
        c_in[i][j] = 32'(8*i + j);
    op_if.op_valid = 1'b1;
    applyStimulus(1, 1'b1, ADDR_LINEAR, 1'b0);
    checkOutput("t3_wben", 64'(wben), 64'd1);
    checkOutput("t3_we", 64'(we), 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("t3_op_ready_pre", 64'(op_if.op_ready), 64'd0);
    bad = 0;
    for (int i = 0; i < LANES; i++)
      for (int j = 0; j < LANES; j++)
        if (c[i][j] !== 32'(8*i + j)) bad++;
    checkOutput("t3_c_all", 64'(bad), 64'd0);
    checkOutput("t3_c77", 64'(c[7][7]), 64'd63);
    step();
    checkOutput("t3_wben_off", 64'(wben), 64'd0);
    checkOutput("t3_we_off", 64'(we), 64'd0);
    checkOutput("t3_op_ready_feed", 64'(op_if.op_ready), 64'd1);
    step();
    op_if.op_valid = 1'b0;
    finish_job("t3_done");

    // ---------------- test 4: drain timeout ----------------
    op_if.op_valid = 1'b1;
    applyStimulus(1, 1'b0, ADDR_TRANSPOSE, 1'b0);
    step();
    op_if.op_valid = 1'b0;
    checkOutput("t4_err_pre", 64'(err), 64'd0);
    wait_done(100, n);
    checkOutput("t4_done_seen", 64'(done), 64'd1);
    checkOutput("t4_latency", 64'(n), 64'(TMO));
    checkOutput("t4_err", 64'(err), 64'd1);
    step();
    checkOutput("t4_err_sticky", 64'(err), 64'd1);
    op_if.op_valid = 1'b1;
    applyStimulus(1, 1'b0, ADDR_LINEAR, 1'b0);
    checkOutput("t4_err_clear", 64'(err), 64'd0);
    step();
    op_if.op_valid = 1'b0;
    finish_job("t4_done_after");

    // ---------------- test 5: PE (7,7) late ----------------
    op_if.op_valid = 1'b1;
    applyStimulus(1, 1'b0, ADDR_LINEAR, 1'b0);
    step();
    op_if.op_valid = 1'b0;
    out_ready = '1;
    out_ready[7][7] = 1'b0;
    step();
    out_ready = '0;
    seen = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      if (done) seen++;
    end
    checkOutput("t5_no_early_done", 64'(seen), 64'd0);
    out_ready[7][7] = 1'b1;
    step();
    out_ready = '0;
    checkOutput("t5_mask_fill", 64'(done), 64'd0);
    step();
    checkOutput("t5_done", 64'(done), 64'd1);
    step();

    // ---------------- test 6: reset during FEED ----------------
    for (int i = 0; i < LANES; i++) begin
      op_if.a_col[i] = 32'h5500_0000 + 32'(i);
      op_if.b_row[i] = 32'h6600_0000 + 32'(i);
    end
    op_if.op_valid = 1'b1;
    applyStimulus(8, 1'b0, ADDR_STRIDED, 1'b1);
    step();
    step();
    step();
    checkOutput("t6_busy_pre", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_op_ready", 64'(op_if.op_ready), 64'd0);
    checkOutput("t6_edges", 64'({enleft, enup, cmleft, cmup}), 64'd0);
    checkOutput("t6_data", 64'({|aleft, |bup}), 64'd0);
    checkOutput("t6_modes", 64'({addr_type, mixed}), 64'd0);
    checkOutput("t6_flags", 64'({done, err, wben}), 64'd0);
    op_if.op_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    checkOutput("t6_idle", 64'({busy, done}), 64'd0);
    op_if.op_valid = 1'b1;
    applyStimulus(1, 1'b0, ADDR_LINEAR, 1'b0);
    checkOutput("t6_restart_busy", 64'(busy), 64'd1);
    step();
    op_if.op_valid = 1'b0;
    checkOutput("t6_restart_aleft0", 64'(aleft[0]), 64'h5500_0000);
    finish_job("t6_done");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_seq.md
Name: systolic_seq

Overview:
- Sequencer for the 8x8 systolic PE array.
- Accepts one tile job: k_len beats, where each beat is one K-column of A (8 lanes) and one K-row of B (8 lanes).
- Skews the beats into the array's left and top edges with matching enable and last-beat (cm) markers, and optionally preloads accumulators through the c/we/wben path.
- Waits until all 64 PEs report out_ready, then pulses done. Sits between the operand buffers and the array.

Parameters:
- KMAX, 256, maximum beats per job.
- TIMEOUT, 64, cycles allowed after the last beat for all out_ready to assert.
- KW, $clog2(KMAX+1), width of k_len.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- k_len  in  KW  beats in job, 1..KMAX; latched on start
- preload  in  1  latched on start; 1 = load c_in into accumulators before feeding
- addr_type_in  in  params::addrgen_t  latched on start, driven to array addr_type
- mixed_in  in  1  latched on start, driven to array mixed
- c_in  in  8x8x32  preload values, must be stable while busy
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat accepted when op_valid&&op_ready
- a_col  in  8x32  A column, lane i -> array row i
- b_row  in  8x32  B row, lane j -> array column j
- enleft, enup  out  8  array edge enables
- cmleft, cmup  out  8  array edge last-beat markers
- aleft, bup  out  8x32  array edge data
- we  out  8x8  per-PE preload enable
- c  out  8x8x32  preload data
- wben  out  1  preload strobe
- addr_type  out  params::addrgen_t
- mixed  out  1
- out_ready  in  8x8  PE result-ready flags
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag, cleared on next accepted start

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0 (op_ready, enables, cm, data, we, wben, busy, done, err). All delay lines and counters 0.
- States: IDLE, PRELOAD, FEED, DRAIN, DONE.
- IDLE:
  - start=1 latches k_len/preload/addr_type/mixed, sets busy, clears err.
  - Goes to PRELOAD if preload=1, else FEED.
  - start while busy is ignored.
  - k_len=0 is treated as 1.
- PRELOAD: one cycle with wben=1, we=all ones, c=c_in. Then FEED.
- FEED:
  - op_ready=1. A beat counter counts accepted beats.
  - Accepting beat number k_len-1 moves to DRAIN; op_ready drops in the cycle after that acceptance.
  - op_valid=0 inserts a bubble: en=0 for that slot, carried through the skew.
- Skew:
  - Row lane i and column lane j each pass through i+1 (resp. j+1) register stages carrying {en, cm, data}.
  - A beat accepted at cycle t appears on aleft[0]/bup[0] at t+1 and on aleft[7]/bup[7] at t+8.
  - cm is 1 only for the final beat. Data is zeroed when en=0.
- DRAIN:
  - Delay lines keep shifting with en=0 input.
  - An 8x8 sticky mask ORs in out_ready each cycle.
  - When the mask is all ones, go to DONE.
  - A timeout counter starts at DRAIN entry. At TIMEOUT cycles it sets err=1 and goes to DONE.
- DONE: done=1 and busy=0 for one cycle; mask cleared; return to IDLE.
- Out_ready pulses seen during FEED also count toward the mask.
- addr_type/mixed hold their latched values until the next start.
- Reset mid-job aborts immediately. No done is issued and no partial state survives.

Decomposition:
- Add seq_state_t enum and the default constants KMAX_DEF/TIMEOUT_DEF to params (para_pkg.sv).
- One sub-module, skew_line #(DEPTH, W): a parameterised register chain. Instantiate 16 of them (8 row lanes, 8 column lanes).

Test Plan:
1. k_len=1, preload=0, op_valid held 1, out_ready all set 3 cycles after cm reaches lane 7:
   - aleft[0]=a_col[0] at t+1, aleft[7] at t+8.
   - cmleft[i] and cmup[j] each high for exactly one cycle.
   - done one cycle after the mask fills; busy low with done.
2. k_len=4 with op_valid low on the 2nd cycle → enleft[3] pattern 1,0,1,1,1 starting at t+4; cm aligned with the 4th valid beat only.
3. preload=1, c_in[i][j]=8*i+j → wben=1 and we=all ones for exactly one cycle before op_ready rises; c matches c_in.
4. out_ready never asserts → err=1 and done pulse exactly TIMEOUT cycles after DRAIN entry. The next start clears err.
5. Only PE (7,7) out_ready held low, others pulsed once → no done until (7,7) pulses, then done on the following cycle.
6. rst low during FEED with k_len=8 → all outputs 0 asynchronously. After release, state is IDLE and start is accepted normally.
